// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared encodings for the data memory controller
// Contents: access size codes, rsp_err bit positions, controller FSM state type.
package mem_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;
    localparam logic [1:0] SIZE_RSVD = 2'b11;

    localparam int ERR_MISALIGN = 0;
    localparam int ERR_RANGE    = 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

endpackage

// File: rtl/mem_byte_array.sv
// rtl/mem_byte_array.sv - byte storage with 4-lane write enable and registered word read
// Ports:
//   clk    : clock
//   we     : per-lane byte write enable, lane i targets base+i
//   re     : load the read register from base..base+3
//   base   : word-aligned byte index
//   wdata  : lane-aligned write data
//   rdata  : registered read word, holds until the next re
// Storage and read register are intentionally not reset.
module mem_byte_array #(
    parameter int NUM_OF_BYTES = 800,
    parameter int IDX_W        = $clog2(NUM_OF_BYTES)
) (
    input  logic             clk,
    input  logic [3:0]       we,
    input  logic             re,
    input  logic [IDX_W-1:0] base,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata
);

    localparam logic [IDX_W:0] MEM_N = (IDX_W+1)'(NUM_OF_BYTES);

    logic [7:0]     mem_q [NUM_OF_BYTES];
    logic [IDX_W:0] idx   [4];
    logic [31:0]    rdata_q, rdata_d;

    // One extra index bit so base+3 past the end of a non-multiple-of-4 array
    // is detected rather than aliasing to a low address.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            idx[i] = {1'b0, base} + (IDX_W+1)'(i);
        end
    end

    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            for (int i = 0; i < 4; i++) begin
                rdata_d[8*i +: 8] = (idx[i] < MEM_N) ? mem_q[idx[i][IDX_W-1:0]] : 8'h00;
            end
        end
    end

    always_ff @(posedge clk) begin
        rdata_q <= rdata_d;
        for (int i = 0; i < 4; i++) begin
            if (we[i] && (idx[i] < MEM_N)) begin
                mem_q[idx[i][IDX_W-1:0]] <= wdata[8*i +: 8];
            end
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/data_memory_ctrl.sv
// rtl/data_memory_ctrl.sv - handshaked byte/half/word data memory with wait states
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   req_valid/req_ready : request handshake, ready only when idle
//   req_write           : 1 store, 0 load
//   req_size            : 00 byte, 01 half, 10 word, 11 reserved
//   req_unsigned        : load zero-extends when 1, sign-extends when 0
//   req_addr, req_wdata : byte address, right-aligned store data
//   rsp_valid           : one-cycle response pulse
//   rsp_rdata           : extended load data, 0 for stores and errors
//   rsp_err             : bit0 misaligned/reserved size, bit1 out of range
module data_memory_ctrl #(
    parameter int NUM_OF_BYTES = 800,
    parameter int WAIT_STATES  = 0,
    parameter int ADDR_WIDTH   = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  rsp_valid,
    output logic [31:0]           rsp_rdata,
    output logic [1:0]            rsp_err
);
    import mem_pkg::*;

    localparam int                IDX_W     = $clog2(NUM_OF_BYTES);
    localparam logic [3:0]        WAIT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
    localparam logic [ADDR_WIDTH:0] MEM_END = (ADDR_WIDTH+1)'(NUM_OF_BYTES);
    localparam logic [IDX_W-1:0]  BASE_MASK = ~(IDX_W'(3));

    state_e                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [1:0]            size_q, size_d;
    logic                  write_q, write_d;
    logic                  uns_q, uns_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [1:0]            rsp_err_q, rsp_err_d;
    logic [1:0]            rsp_lane_q, rsp_lane_d;
    logic [1:0]            rsp_size_q, rsp_size_d;
    logic                  rsp_uns_q, rsp_uns_d;
    logic                  rsp_load_ok_q, rsp_load_ok_d;

    logic                  accept, commit;
    logic [ADDR_WIDTH-1:0] cur_addr;
    logic [1:0]            cur_size;
    logic                  cur_write, cur_uns;
    logic [31:0]           cur_wdata;
    logic [ADDR_WIDTH:0]   nbytes, addr_end;
    logic [1:0]            err;
    logic [1:0]            lane;
    logic [3:0]            be, mem_we;
    logic                  mem_re;
    logic [31:0]           mem_wdata, mem_rdata, shifted;

    assign accept = req_valid && (state_q == ST_IDLE) && rst_n;

    // With zero wait states the commit edge is the acceptance edge, so the
    // checks must look at the live request instead of the capture registers.
    assign cur_addr  = (state_q == ST_IDLE) ? req_addr     : addr_q;
    assign cur_size  = (state_q == ST_IDLE) ? req_size     : size_q;
    assign cur_write = (state_q == ST_IDLE) ? req_write    : write_q;
    assign cur_uns   = (state_q == ST_IDLE) ? req_unsigned : uns_q;
    assign cur_wdata = (state_q == ST_IDLE) ? req_wdata    : wdata_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        size_d  = size_q;
        write_d = write_q;
        uns_d   = uns_q;
        wdata_d = wdata_q;
        commit  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    addr_d  = req_addr;
                    size_d  = req_size;
                    write_d = req_write;
                    uns_d   = req_unsigned;
                    wdata_d = req_wdata;
                    if (WAIT_STATES == 0) begin
                        state_d = ST_RESP;
                        commit  = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = WAIT_INIT;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_RESP;
                    commit  = rst_n;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Range is checked one bit wider than the address so that accesses
    // near the top of the address space cannot wrap back into range.
    always_comb begin
        err = 2'b00;
        err[ERR_MISALIGN] = ((cur_size == SIZE_HALF) && cur_addr[0]) ||
                            ((cur_size == SIZE_WORD) && (cur_addr[1:0] != 2'b00)) ||
                            (cur_size == SIZE_RSVD);
        case (cur_size)
            SIZE_HALF: nbytes = (ADDR_WIDTH+1)'(2);
            SIZE_WORD: nbytes = (ADDR_WIDTH+1)'(4);
            default:   nbytes = (ADDR_WIDTH+1)'(1);
        endcase
        addr_end = {1'b0, cur_addr} + nbytes;
        err[ERR_RANGE] = (addr_end > MEM_END);
    end

    always_comb begin
        lane = cur_addr[1:0];
        case (cur_size)
            SIZE_BYTE: be = 4'b0001 << lane;
            SIZE_HALF: be = 4'b0011 << lane;
            default:   be = 4'b1111;
        endcase
        mem_wdata = cur_wdata << {lane, 3'b000};
        mem_we    = (commit && cur_write && (err == 2'b00)) ? be : 4'b0000;
        mem_re    = commit && !cur_write && (err == 2'b00);
    end

    mem_byte_array #(
        .NUM_OF_BYTES (NUM_OF_BYTES),
        .IDX_W        (IDX_W)
    ) u_array (
        .clk   (clk),
        .we    (mem_we),
        .re    (mem_re),
        .base  (cur_addr[IDX_W-1:0] & BASE_MASK),
        .wdata (mem_wdata),
        .rdata (mem_rdata)
    );

    // Extension controls are latched at commit so rsp_rdata stays stable
    // while the next request is captured and waiting.
    always_comb begin
        rsp_err_d     = rsp_err_q;
        rsp_lane_d    = rsp_lane_q;
        rsp_size_d    = rsp_size_q;
        rsp_uns_d     = rsp_uns_q;
        rsp_load_ok_d = rsp_load_ok_q;
        if (commit) begin
            rsp_err_d     = err;
            rsp_lane_d    = lane;
            rsp_size_d    = cur_size;
            rsp_uns_d     = cur_uns;
            rsp_load_ok_d = !cur_write && (err == 2'b00);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            cnt_q         <= 4'd0;
            addr_q        <= '0;
            size_q        <= 2'b00;
            write_q       <= 1'b0;
            uns_q         <= 1'b0;
            wdata_q       <= 32'h0;
            rsp_err_q     <= 2'b00;
            rsp_lane_q    <= 2'b00;
            rsp_size_q    <= 2'b00;
            rsp_uns_q     <= 1'b0;
            rsp_load_ok_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            addr_q        <= addr_d;
            size_q        <= size_d;
            write_q       <= write_d;
            uns_q         <= uns_d;
            wdata_q       <= wdata_d;
            rsp_err_q     <= rsp_err_d;
            rsp_lane_q    <= rsp_lane_d;
            rsp_size_q    <= rsp_size_d;
            rsp_uns_q     <= rsp_uns_d;
            rsp_load_ok_q <= rsp_load_ok_d;
        end
    end

    always_comb begin
        shifted = mem_rdata >> {rsp_lane_q, 3'b000};
        case (rsp_size_q)
            SIZE_BYTE: rsp_rdata = {{24{!rsp_uns_q && shifted[7]}}, shifted[7:0]};
            SIZE_HALF: rsp_rdata = {{16{!rsp_uns_q && shifted[15]}}, shifted[15:0]};
            default:   rsp_rdata = shifted;
        endcase
        if (!rsp_load_ok_q) begin
            rsp_rdata = 32'h0;
        end
    end

    assign req_ready = (state_q == ST_IDLE);
    assign rsp_valid = (state_q == ST_RESP);
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_data_memory_ctrl.sv
// tb/tb_data_memory_ctrl.sv - directed self-checking bench for data_memory_ctrl
module tb_data_memory_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_write = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;

    logic        valid0 = 1'b0, valid1 = 1'b0;
    logic        ready0, ready1;
    logic        rv0, rv1;
    logic [31:0] rd0, rd1;
    logic [1:0]  er0, er1;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    data_memory_ctrl #(.NUM_OF_BYTES(800), .WAIT_STATES(0), .ADDR_WIDTH(32)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .req_valid(valid0), .req_ready(ready0),
        .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rv0), .rsp_rdata(rd0), .rsp_err(er0)
    );

    data_memory_ctrl #(.NUM_OF_BYTES(800), .WAIT_STATES(3), .ADDR_WIDTH(32)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .req_valid(valid1), .req_ready(ready1),
        .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rv1), .rsp_rdata(rd1), .rsp_err(er1)
    );

    // Drives one request to DUT sel (0: no wait states, 1: three), returns the
    // response and the number of negedges from acceptance to rsp_valid.
    task automatic op(input int sel, input logic w, input logic [1:0] sz, input logic u,
                      input logic [31:0] a, input logic [31:0] wd,
                      output logic [31:0] rd, output logic [1:0] er, output int lat);
        int guard;
        @(negedge clk);
        req_write = w; req_size = sz; req_unsigned = u; req_addr = a; req_wdata = wd;
        if (sel == 0) valid0 = 1'b1; else valid1 = 1'b1;
        guard = 0;
        while (((sel == 0) ? !ready0 : !ready1) && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        @(posedge clk);
        @(negedge clk);
        valid0 = 1'b0; valid1 = 1'b0;
        lat = 1;
        while (!((sel == 0) ? rv0 : rv1) && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        rd = (sel == 0) ? rd0 : rd1;
        er = (sel == 0) ? er0 : er1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++; if (ready0 !== 1'b1) begin failures++; $display("FAIL reset_ready0 got=%b exp=1", ready0); end
        checks++; if (rv0 !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid0 got=%b exp=0", rv0); end
        checks++; if (rd0 !== 32'h0) begin failures++; $display("FAIL reset_rdata0 got=%h exp=0", rd0); end
        checks++; if (er0 !== 2'b00) begin failures++; $display("FAIL reset_err0 got=%b exp=00", er0); end
        checks++; if (ready1 !== 1'b1) begin failures++; $display("FAIL reset_ready1 got=%b exp=1", ready1); end
        checks++; if (rv1 !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid1 got=%b exp=0", rv1); end
    endtask

    task automatic test_word();
        logic [31:0] rd; logic [1:0] er; int lat;
        op(0, 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, rd, er, lat);
        checks++; if (lat !== 1) begin failures++; $display("FAIL sw_latency got=%0d exp=1", lat); end
        checks++; if (er !== 2'b00) begin failures++; $display("FAIL sw_err got=%b exp=00", er); end
        checks++; if (rd !== 32'h0) begin failures++; $display("FAIL sw_rdata got=%h exp=0", rd); end
        op(0, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, rd, er, lat);
        checks++; if (lat !== 1) begin failures++; $display("FAIL lw_latency got=%0d exp=1", lat); end
        checks++; if (rd !== 32'hDEADBEEF) begin failures++; $display("FAIL lw_rdata got=%h exp=deadbeef", rd); end
        checks++; if (er !== 2'b00) begin failures++; $display("FAIL lw_err got=%b exp=00", er); end
        @(negedge clk);
        checks++; if (rv0 !== 1'b0) begin failures++; $display("FAIL lw_pulse_width got=%b exp=0", rv0); end
        checks++; if (rd0 !== 32'hDEADBEEF) begin failures++; $display("FAIL lw_rdata_hold got=%h exp=deadbeef", rd0); end
        op(0, 1'b0, 2'b00, 1'b0, 32'h10, 32'h0, rd, er, lat);
        checks++; if (rd !== 32'hFFFFFFEF) begin failures++; $display("FAIL lb_signed got=%h exp=ffffffef", rd); end
        op(0, 1'b0, 2'b00, 1'b1, 32'h10, 32'h0, rd, er, lat);
        checks++; if (rd !== 32'h000000EF) begin failures++; $display("FAIL lbu got=%h exp=000000ef", rd); end
    endtask

    task automatic test_merge();
        logic [31:0] rd; logic [1:0] er; int lat;
        op(0, 1'b1, 2'b10, 1'b0, 32'h20, 32'h11223344, rd, er, lat);
        op(0, 1'b1, 2'b00, 1'b0, 32'h21, 32'h000000AA, rd, er, lat);
        op(0, 1'b1, 2'b01, 1'b0, 32'h22, 32'h0000BBCC, rd, er, lat);
        op(0, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, rd, er, lat);
        checks++; if (rd !== 32'hBBCCAA44) begin failures++; $display("FAIL merge_word got=%h exp=bbccaa44", rd); end
        op(0, 1'b0, 2'b01, 1'b0, 32'h22, 32'h0, rd, er, lat);
        checks++; if (rd !== 32'hFFFFBBCC) begin failures++; $display("FAIL lh_signed got=%h exp=ffffbbcc", rd); end
    endtask

    task automatic test_errors();
        logic [31:0] rd; logic [1:0] er; int lat;
        op(0, 1'b1, 2'b10, 1'b0, 32'h13, 32'h12345678, rd, er, lat);
        checks++; if (er !== 2'b01) begin failures++; $display("FAIL err_misalign got=%b exp=01", er); end
        op(0, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, rd, er, lat);
        checks++; if (rd !== 32'hDEADBEEF) begin failures++; $display("FAIL err_no_write got=%h exp=deadbeef", rd); end
        op(0, 1'b0, 2'b10, 1'b0, 32'd796, 32'h0, rd, er, lat);
        checks++; if (er !== 2'b00) begin failures++; $display("FAIL err_w796 got=%b exp=00", er); end
        op(0, 1'b0, 2'b10, 1'b0, 32'd797, 32'h0, rd, er, lat);
        checks++; if (er !== 2'b11) begin failures++; $display("FAIL err_w797 got=%b exp=11", er); end
        checks++; if (rd !== 32'h0) begin failures++; $display("FAIL err_w797_rdata got=%h exp=0", rd); end
        op(0, 1'b0, 2'b00, 1'b0, 32'd799, 32'h0, rd, er, lat);
        checks++; if (er !== 2'b00) begin failures++; $display("FAIL err_b799 got=%b exp=00", er); end
        op(0, 1'b0, 2'b00, 1'b0, 32'd800, 32'h0, rd, er, lat);
        checks++; if (er !== 2'b10) begin failures++; $display("FAIL err_b800 got=%b exp=10", er); end
        checks++; if (rd !== 32'h0) begin failures++; $display("FAIL err_b800_rdata got=%h exp=0", rd); end
        op(0, 1'b0, 2'b10, 1'b0, 32'hFFFFFFFC, 32'h0, rd, er, lat);
        checks++; if (er !== 2'b10) begin failures++; $display("FAIL err_wrap got=%b exp=10", er); end
        op(0, 1'b0, 2'b11, 1'b0, 32'h40, 32'h0, rd, er, lat);
        checks++; if (er !== 2'b01) begin failures++; $display("FAIL err_rsvd got=%b exp=01", er); end
        checks++; if (rd !== 32'h0) begin failures++; $display("FAIL err_rsvd_rdata got=%h exp=0", rd); end
    endtask

    task automatic test_wait_states();
        logic [31:0] rd, rd_a, rd_b; logic [1:0] er; int lat;
        int first_rsp, second_rsp, ready_low, rv_early;
        logic ready5;
        op(1, 1'b1, 2'b10, 1'b0, 32'h40, 32'h01020304, rd, er, lat);
        checks++; if (lat !== 4) begin failures++; $display("FAIL ws_latency got=%0d exp=4", lat); end
        op(1, 1'b1, 2'b10, 1'b0, 32'h44, 32'hA5A5A5A5, rd, er, lat);
        @(negedge clk);
        req_write = 1'b0; req_size = 2'b10; req_unsigned = 1'b0; req_addr = 32'h40;
        valid1 = 1'b1;
        @(posedge clk);
        first_rsp = -1; second_rsp = -1; ready_low = 0; rv_early = 0; ready5 = 1'b0;
        rd_a = 32'h0; rd_b = 32'h0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (c == 1) req_addr = 32'h44;
            if (c <= 4 && !ready1) ready_low++;
            if (c <= 3 && rv1) rv_early++;
            if (c == 5) ready5 = ready1;
            if (c == 6) valid1 = 1'b0;
            if (rv1) begin
                if (first_rsp < 0) begin first_rsp = c; rd_a = rd1; end
                else if (second_rsp < 0) begin second_rsp = c; rd_b = rd1; end
            end
        end
        checks++; if (ready_low !== 4) begin failures++; $display("FAIL ws_ready_low got=%0d exp=4", ready_low); end
        checks++; if (rv_early !== 0) begin failures++; $display("FAIL ws_early_rsp got=%0d exp=0", rv_early); end
        checks++; if (first_rsp !== 4) begin failures++; $display("FAIL ws_first_rsp got=%0d exp=4", first_rsp); end
        checks++; if (rd_a !== 32'h01020304) begin failures++; $display("FAIL ws_addr_change got=%h exp=01020304", rd_a); end
        checks++; if (ready5 !== 1'b1) begin failures++; $display("FAIL ws_ready_idle got=%b exp=1", ready5); end
        checks++; if (second_rsp !== 9) begin failures++; $display("FAIL ws_second_rsp got=%0d exp=9", second_rsp); end
        checks++; if (rd_b !== 32'hA5A5A5A5) begin failures++; $display("FAIL ws_second_rdata got=%h exp=a5a5a5a5", rd_b); end
    endtask

    task automatic test_reset_mid_op();
        logic [31:0] rd; logic [1:0] er; int lat; int rv_seen;
        op(1, 1'b1, 2'b00, 1'b0, 32'h30, 32'h00000000, rd, er, lat);
        op(1, 1'b1, 2'b00, 1'b0, 32'h34, 32'h00000077, rd, er, lat);
        @(negedge clk);
        req_write = 1'b1; req_size = 2'b00; req_unsigned = 1'b0; req_addr = 32'h30; req_wdata = 32'h55;
        valid1 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        valid1 = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++; if (ready1 !== 1'b1) begin failures++; $display("FAIL rst_mid_ready got=%b exp=1", ready1); end
        @(negedge clk);
        rst_n = 1'b1;
        rv_seen = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (rv1) rv_seen++;
        end
        checks++; if (rv_seen !== 0) begin failures++; $display("FAIL rst_mid_no_rsp got=%0d exp=0", rv_seen); end
        op(1, 1'b0, 2'b00, 1'b1, 32'h30, 32'h0, rd, er, lat);
        checks++; if (rd !== 32'h00000000) begin failures++; $display("FAIL rst_mid_dropped got=%h exp=0", rd); end
        op(1, 1'b0, 2'b00, 1'b1, 32'h34, 32'h0, rd, er, lat);
        checks++; if (rd !== 32'h00000077) begin failures++; $display("FAIL rst_persist3 got=%h exp=77", rd); end
        op(0, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, rd, er, lat);
        checks++; if (rd !== 32'hDEADBEEF) begin failures++; $display("FAIL rst_persist0 got=%h exp=deadbeef", rd); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_word();
        test_merge();
        test_errors();
        test_wait_states();
        test_reset_mid_op();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
